// File: rtl/hyster_window_ctrl_pkg.sv
// Shared definitions for the hysteresis window sequencer.
//   DSIZE     default bits per edge-magnitude pixel
//   state_t   controller FSM states
//   CENTER    tap index of the window centre (row-major, tap 0 = top-left)
//   win_lsb   LSB position of a tap inside the packed 3x3 window
package hyster_pkg;

  localparam int unsigned DSIZE    = 4;
  localparam int unsigned WIN_TAPS = 9;
  localparam int unsigned CENTER   = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  // Tap 0 (top-left) sits in the MSBs, tap 8 (bottom-right) in the LSBs.
  function automatic int unsigned win_lsb(input int unsigned tap, input int unsigned dw);
    return (WIN_TAPS - 1 - tap) * dw;
  endfunction

endpackage

// File: rtl/hyster_window_ctrl_line_buf.sv
// Two-line buffer for the 3x3 window builder.
//   i_clk   clock
//   i_adv   advance: shift the addressed column down one line and store i_data
//   i_col   shared read/write column pointer
//   i_data  pixel entering the current line
//   o_r2    pixel two lines above at i_col
//   o_r1    pixel one line above at i_col
//   o_cur   current-line pixel (i_data passed through)
// Contents are not reset; the controller pads every out-of-frame tap.
module hyster_line_buf #(
  parameter int unsigned DSIZE = 4,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned AW    = 10
) (
  input  logic             i_clk,
  input  logic             i_adv,
  input  logic [AW-1:0]    i_col,
  input  logic [DSIZE-1:0] i_data,
  output logic [DSIZE-1:0] o_r2,
  output logic [DSIZE-1:0] o_r1,
  output logic [DSIZE-1:0] o_cur
);

  logic [DSIZE-1:0] mem_r2 [IMG_W];
  logic [DSIZE-1:0] mem_r1 [IMG_W];

  always_comb begin
    o_r2  = mem_r2[i_col];
    o_r1  = mem_r1[i_col];
    o_cur = i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_adv) begin
      mem_r2[i_col] <= mem_r1[i_col];
      mem_r1[i_col] <= i_data;
    end
  end

endmodule

// File: rtl/hyster_window_ctrl.sv
// Window sequencer feeding the HYSTER thresholding stage.
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_valid/o_ready pixel handshake (accept = i_valid & o_ready)
//   i_sof           start of frame, marks pixel (0,0) on accept
//   i_data          raster-order input pixel
//   i_seg_width     threshold, latched on the sof accept
//   o_window        zero-padded 3x3 window, top-left in the MSBs
//   o_win_valid     one pulse per window
//   o_seg_width     per-frame shadow threshold
//   o_pix_valid     o_win_valid delayed HYST_LAT cycles
//   o_pix_last      with o_pix_valid for pixel (H-1,W-1) of a completed frame
//   o_busy          FSM not idle
module hyster_window_ctrl #(
  parameter int unsigned DSIZE    = hyster_pkg::DSIZE,
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned HYST_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_sof,
  input  logic [DSIZE-1:0]   i_data,
  input  logic [3:0]         i_seg_width,
  output logic [DSIZE*9-1:0] o_window,
  output logic               o_win_valid,
  output logic [3:0]         o_seg_width,
  output logic               o_pix_valid,
  output logic               o_pix_last,
  output logic               o_busy
);
  import hyster_pkg::*;

  localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned COLW = 3 * DSIZE;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t state, state_nx;

  logic [CW-1:0]       in_col, em_col, lb_col;
  logic [RW-1:0]       in_row, em_row;
  logic [COLW-1:0]     col_a, col_b, col_new;
  logic [COLW-1:0]     lc, mc, rc, row_mask;
  logic [DSIZE-1:0]    lb_r2, lb_r1, lb_cur, feed_data;
  logic                accept, sof_acc, adv, emit, last_emit, win_last;
  logic [DSIZE*9-1:0]  win_nx;
  logic [HYST_LAT-1:0] pv_sr, pl_sr;

  assign o_ready     = (state != FLUSH);
  assign o_busy      = (state != IDLE);
  assign o_pix_valid = pv_sr[HYST_LAT-1];
  assign o_pix_last  = pl_sr[HYST_LAT-1];

  hyster_line_buf #(
    .DSIZE (DSIZE),
    .IMG_W (IMG_W),
    .AW    (CW)
  ) u_line_buf (
    .i_clk  (i_clk),
    .i_adv  (adv),
    .i_col  (lb_col),
    .i_data (feed_data),
    .o_r2   (lb_r2),
    .o_r1   (lb_r1),
    .o_cur  (lb_cur)
  );

  always_comb begin
    accept    = i_valid & o_ready;
    sof_acc   = accept & i_sof;
    feed_data = (state == FLUSH) ? '0 : i_data;
    lb_col    = sof_acc ? '0 : in_col;
    adv       = sof_acc | (state == FLUSH) | (accept & ((state == FILL) | (state == RUN)));
    emit      = 1'b0;
    state_nx  = state;
    if (sof_acc) begin
      state_nx = FILL;
    end else begin
      case (state)
        IDLE: ;
        FILL: begin
          // pixel index W+1 is (row 1, col 1); for a 2x2 frame it is also the last pixel
          if (accept && in_row == RW'(1) && in_col == CW'(1)) begin
            emit     = 1'b1;
            state_nx = (in_row == ROW_LAST && in_col == COL_LAST) ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            emit = 1'b1;
            if (in_row == ROW_LAST && in_col == COL_LAST) state_nx = FLUSH;
          end
        end
        FLUSH: begin
          emit = 1'b1;
          if (em_row == ROW_LAST && em_col == COL_LAST) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
    last_emit = emit && em_row == ROW_LAST && em_col == COL_LAST;
  end

  // Window columns: col_a = centre col-1, col_b = centre col, col_new = centre col+1.
  // Padding is decided from the emit position so stale line data never leaks in.
  always_comb begin
    col_new  = {lb_r2, lb_r1, lb_cur};
    row_mask = {{DSIZE{em_row != '0}}, {DSIZE{1'b1}}, {DSIZE{em_row != ROW_LAST}}};
    lc       = ((em_col == '0) ? '0 : col_a) & row_mask;
    mc       = col_b & row_mask;
    rc       = ((em_col == COL_LAST) ? '0 : col_new) & row_mask;
    win_nx   = {lc[COLW-1 -: DSIZE], mc[COLW-1 -: DSIZE], rc[COLW-1 -: DSIZE],
                lc[2*DSIZE-1 -: DSIZE], mc[2*DSIZE-1 -: DSIZE], rc[2*DSIZE-1 -: DSIZE],
                lc[DSIZE-1:0], mc[DSIZE-1:0], rc[DSIZE-1:0]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      in_col      <= '0;
      in_row      <= '0;
      em_col      <= '0;
      em_row      <= '0;
      col_a       <= '0;
      col_b       <= '0;
      o_seg_width <= '0;
      o_window    <= '0;
      o_win_valid <= 1'b0;
      win_last    <= 1'b0;
      pv_sr       <= '0;
      pl_sr       <= '0;
    end else begin
      state       <= state_nx;
      o_win_valid <= emit;
      win_last    <= last_emit;
      pv_sr       <= (pv_sr << 1) | HYST_LAT'(o_win_valid);
      pl_sr       <= (pl_sr << 1) | HYST_LAT'(win_last);
      if (emit) o_window <= win_nx;
      if (adv) begin
        col_a <= col_b;
        col_b <= col_new;
      end
      if (sof_acc) begin
        o_seg_width <= i_seg_width;
        in_col      <= CW'(1);
        in_row      <= '0;
        em_col      <= '0;
        em_row      <= '0;
      end else begin
        if (adv) begin
          if (in_col == COL_LAST) begin
            in_col <= '0;
            in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
          end else begin
            in_col <= in_col + CW'(1);
          end
        end
        if (emit) begin
          if (em_col == COL_LAST) begin
            em_col <= '0;
            em_row <= (em_row == ROW_LAST) ? '0 : em_row + RW'(1);
          end else begin
            em_col <= em_col + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hyster_window_ctrl.sv
module tb_hyster_window_ctrl;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int D   = 4;
  localparam int LAT = 2;
  localparam int N   = W * H;
  localparam int HL  = LAT + 1;

  logic           i_clk, i_rst, i_valid, i_sof;
  logic [D-1:0]   i_data;
  logic [3:0]     i_seg_width;
  logic           o_ready, o_win_valid, o_pix_valid, o_pix_last, o_busy;
  logic [D*9-1:0] o_window;
  logic [3:0]     o_seg_width;

  hyster_window_ctrl #(
    .DSIZE    (D),
    .IMG_W    (W),
    .IMG_H    (H),
    .HYST_LAT (LAT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sof       (i_sof),
    .i_data      (i_data),
    .i_seg_width (i_seg_width),
    .o_window    (o_window),
    .o_win_valid (o_win_valid),
    .o_seg_width (o_seg_width),
    .o_pix_valid (o_pix_valid),
    .o_pix_last  (o_pix_last),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // reference model state: current frame image plus progress through it
  int       fpix [N];
  bit       ref_active;
  int       ref_n;
  int       ref_flush;
  logic [3:0] ref_seg;
  logic [HL-1:0] hv, hl;
  int       pl_count, rdy0_count;
  bit       const_chk;

  localparam logic [D*9-1:0] W00 = {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd5, 4'd6};
  localparam logic [D*9-1:0] W23 = {4'd7, 4'd8, 4'd0, 4'd11, 4'd12, 4'd0, 4'd0, 4'd0, 4'd0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // 3x3 neighbourhood of raster position m, zero outside the image
  function automatic logic [D*9-1:0] model_win(input int m);
    logic [D*9-1:0] w;
    int r, c, v;
    r = m / W;
    c = m % W;
    w = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (r + dr < 0 || r + dr >= H || c + dc < 0 || c + dc >= W) v = 0;
        else v = fpix[(r + dr) * W + c + dc];
        w = (w << D) | (D*9)'(v);
      end
    end
    return w;
  endfunction

  task automatic tick(input bit rst, input bit v, input bit sof,
                      input logic [D-1:0] d, input logic [3:0] sw);
    bit acc, ew, el;
    int m;
    logic [D*9-1:0] ewin;
    i_rst = rst; i_valid = v; i_sof = sof; i_data = d; i_seg_width = sw;
    ew = 0; el = 0; m = 0; ewin = '0;
    if (rst) begin
      ref_active = 0; ref_n = 0; ref_flush = 0; ref_seg = '0;
    end else begin
      acc = v && (ref_flush == 0);
      if (acc && sof) begin
        ref_seg = sw; fpix[0] = int'(d); ref_n = 1; ref_active = 1;
      end else if (acc && ref_active) begin
        fpix[ref_n] = int'(d);
        if (ref_n >= W + 1) begin ew = 1; m = ref_n - W - 1; end
        ref_n++;
        if (ref_n == N) begin ref_active = 0; ref_flush = W + 1; end
      end else if (ref_flush > 0) begin
        ew = 1; m = N - ref_flush; ref_flush--;
      end
      if (ew) ewin = model_win(m);
      el = ew && (m == N - 1);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    if (rst) begin hv = '0; hl = '0; end
    else begin
      hv = (hv << 1) | HL'(ew);
      hl = (hl << 1) | HL'(el);
    end
    chk("win_valid", o_win_valid, ew);
    if (ew) chk("window", o_window, ewin);
    if (const_chk && ew && m == 0) chk("window_0_0", o_window, W00);
    if (const_chk && ew && m == N - 1) chk("window_2_3", o_window, W23);
    chk("pix_valid", o_pix_valid, hv[LAT]);
    chk("pix_last", o_pix_last, hl[LAT]);
    chk("ready", o_ready, ref_flush == 0);
    chk("busy", o_busy, ref_active || ref_flush > 0);
    chk("seg_width", o_seg_width, ref_seg);
    if (o_pix_last === 1'b1) pl_count++;
    if (o_ready === 1'b0) rdy0_count++;
  endtask

  task automatic send_frame(input bit toggle, input logic [3:0] sw,
                            input logic [3:0] sw_mid, input bit rnd);
    logic [D-1:0] d;
    for (int i = 0; i < N; i++) begin
      d = rnd ? D'($urandom_range(0, 15)) : D'(i + 1);
      tick(0, 1, i == 0, d, (i == 0) ? sw : sw_mid);
      if (toggle) tick(0, 0, 0, 4'hf, sw_mid);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < W + 1 + LAT + 3; i++) tick(0, 0, 0, '0, 4'h0);
  endtask

  initial begin
    int sent;
    hv = '0; hl = '0; const_chk = 0;
    ref_active = 0; ref_n = 0; ref_flush = 0; ref_seg = '0;
    for (int i = 0; i < N; i++) fpix[i] = 0;

    // reset state
    tick(1, 0, 0, '0, 4'h0);
    chk("reset_window", o_window, '0);
    tick(0, 0, 0, '0, 4'h0);

    // directed frame 1..12, threshold 5, threshold input moved to 9 mid-frame
    const_chk = 1; pl_count = 0;
    send_frame(0, 4'd5, 4'd9, 0);
    drain();
    chk("pix_last_once", pl_count, 1);
    chk("seg_holds_5", o_seg_width, 4'd5);
    const_chk = 0;

    // same frame with valid toggling
    const_chk = 1; rdy0_count = 0; pl_count = 0;
    send_frame(1, 4'd5, 4'd5, 0);
    drain();
    chk("flush_ready_low_cycles", rdy0_count, 5);
    chk("pix_last_once_toggle", pl_count, 1);
    const_chk = 0;

    // pixel without sof in IDLE is dropped
    tick(0, 1, 0, 4'd9, 4'd1);
    chk("idle_drop_busy", o_busy, 1'b0);
    drain();

    // abort: sof again at index 7 with threshold 3
    pl_count = 0;
    for (int i = 0; i < 7; i++) tick(0, 1, i == 0, D'(i + 1), 4'd5);
    tick(0, 1, 1, 4'd14, 4'd3);
    chk("abort_seg", o_seg_width, 4'd3);
    for (int i = 1; i < N; i++) tick(0, 1, 0, D'($urandom_range(0, 15)), 4'd7);
    drain();
    chk("abort_pix_last_once", pl_count, 1);

    // reset during FLUSH
    send_frame(0, 4'd6, 4'd6, 1);
    tick(0, 0, 0, '0, 4'h0);
    tick(0, 0, 0, '0, 4'h0);
    tick(1, 0, 0, '0, 4'h0);
    chk("rst_flush_win_valid", o_win_valid, 1'b0);
    chk("rst_flush_pix_valid", o_pix_valid, 1'b0);
    chk("rst_flush_busy", o_busy, 1'b0);
    chk("rst_flush_ready", o_ready, 1'b1);
    drain();

    // randomized frames with random valid gaps and unqualified sof
    for (int f = 0; f < 4; f++) begin
      sent = 0;
      pl_count = 0;
      for (int cyc = 0; cyc < 400 && sent < N; cyc++) begin
        if ($urandom_range(0, 2) != 0) begin
          tick(0, 1, sent == 0, D'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
          sent++;
        end else begin
          tick(0, 0, 1'($urandom_range(0, 1)), D'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
      end
      chk("rand_frame_sent", sent, N);
      drain();
      chk("rand_pix_last_once", pl_count, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hyster_window_ctrl.md
Name: hyster_window_ctrl

Overview:
- Sequencer that feeds the hysteresis thresholding stage (HYSTER) from a raster stream of DSIZE-bit edge-magnitude pixels.
- Buffers two lines and builds zero-padded 3x3 windows in HYSTER's packed format.
- Flushes the final row and column at end of frame, and latches the per-frame threshold.
- Emits valid/last flags delayed to line up with HYSTER's one-cycle registered output.

Parameters:
- DSIZE, 4, bits per pixel.
- IMG_W, 640, pixels per line (>=2).
- IMG_H, 480, lines per frame (>=2).
- HYST_LAT, 1, downstream HYSTER latency in cycles; sets the o_pix_* delay.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_valid  in  1  input pixel valid.
- o_ready  out  1  controller accepts a pixel this cycle. Accept = i_valid & o_ready.
- i_sof  in  1  start of frame; qualified by accept; marks pixel (0,0).
- i_data  in  DSIZE  input pixel, raster order.
- i_seg_width  in  4  threshold configuration; sampled on the sof accept.
- o_window  out  DSIZE*9  3x3 window, row-major. Top-left in the MSBs; center in slice 4.
- o_win_valid  out  1  o_window valid (1-cycle pulse per window).
- o_seg_width  out  4  shadow threshold for HYSTER; stable for the whole frame.
- o_pix_valid  out  1  o_win_valid delayed HYST_LAT cycles; qualifies HYSTER o_pixel.
- o_pix_last  out  1  asserted with o_pix_valid for the final pixel (H-1,W-1) of a completed frame.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0 except o_ready=1. State IDLE; counters and o_seg_width cleared. Line-buffer contents are don't-care.
- Counters: accepted pixel index n, split into col/row; emit index m, split into col/row.
- Latency: the window centred at pixel m is registered in the cycle after accept of pixel m+W+1. During FLUSH the same advance happens with internal zero data instead of an accepted pixel.
- Padding: neighbours outside the frame are 0.
  - Left column 0 when col=0; right column 0 when col=W-1.
  - Top row 0 when row=0; bottom row 0 when row=H-1.
  - Padding applies per emitted center, never from stale line-buffer data.
- FSM states:
  - IDLE: o_ready=1. Accept with i_sof -> FILL, n=1, latch o_seg_width. Accept without i_sof -> pixel dropped, stay IDLE.
  - FILL: o_ready=1, no windows. After accepting index W+1 the first window is emitted -> RUN. W+1 <= W*H is guaranteed by the parameter limits.
  - RUN: o_ready=1. Each accept emits exactly one window. Accept of the last pixel (n=W*H-1) -> FLUSH.
  - FLUSH: o_ready=0. One window per cycle for W+1 cycles (m = W*H-W-1 .. W*H-1). After the final window -> IDLE.
- Exactly W*H windows per completed frame, emitted in raster order.
- Stall: i_valid=0 in FILL/RUN freezes all state. No bubbles are inserted in FLUSH.
- i_sof accepted in FILL or RUN: frame aborted, no further windows for the old frame, no o_pix_last. That pixel becomes index 0 of a new frame, with a new o_seg_width latch, and the state -> FILL.
- o_seg_width changes only on a sof accept. A change on i_seg_width mid-frame is ignored.
- o_pix_valid/o_pix_last: shift register of depth HYST_LAT fed by o_win_valid and the last-window flag. It continues draining after the FSM returns to IDLE.
- Reset mid-frame: on the next edge all state is as at reset; pending o_pix_* entries are cleared.

Decomposition:
- Package hyster_pkg:
  - DSIZE;
  - state enum {IDLE, FILL, RUN, FLUSH};
  - window index constants (CENTER=4, slice helper).
- Sub-module hyster_line_buf: two IMG_W x DSIZE line memories with a single write/read pointer. One read per advance returns the column (row-2, row-1, current).
- The controller holds the 3x3 shift registers, counters, padding mux and FSM.

Test Plan:
- Reset then W=4,H=3 frame, pixels 1..12, i_seg_width=5 -> 12 o_win_valid pulses in raster order.
  - First pulse is 1 cycle after accept of pixel index 5.
  - Window(0,0) = {0,0,0, 0,1,2, 0,5,6}.
  - Window(2,3) = {7,8,0, 11,12,0, 0,0,0}.
  - o_seg_width=5.
  - o_pix_last exactly once, HYST_LAT after the last window.
- Same frame with i_valid toggling 1-0-1-0 -> identical window sequence; o_ready=0 for exactly 5 FLUSH cycles.
- Pixel accepted without i_sof in IDLE, value 9 -> dropped; no windows; o_busy stays 0.
- i_sof asserted again at index 7 with i_seg_width=3 -> no o_pix_last for the old frame; a new full 12-window frame follows with o_seg_width=3.
- i_rst asserted during FLUSH -> next cycle o_win_valid=0, o_pix_valid=0, o_busy=0, o_ready=1.
- i_seg_width changed to 9 mid-frame -> o_seg_width holds 5 until the next sof.
